alu_op_sequencer: RTL and testbench

//  Request/response front end for the 8-bit aluBasic datapath. Accepts one operation at a time,

---
 rtl/alu_seq_pkg.sv | 43 ++++
 rtl/alu_op_sequencer_if.sv | 31 +++
 rtl/alu_basic.sv | 55 +++++
 rtl/alu_op_sequencer.sv | 147 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU operation sequencer: request opcodes, aluBasic
// function codes and the sequencer FSM states.
package alu_seq_pkg;

    localparam int SEQ_WIDTH    = 8;
    localparam int SEQ_MUL_ITER = 8;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_INC  = 3'b010,
        OP_DEC  = 3'b011,
        OP_PASS = 3'b100,
        OP_NEG  = 3'b101,
        OP_CMP  = 3'b110,
        OP_MUL  = 3'b111
    } op_e;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_INC  = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_DEC  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_e;

    // ALU function used by the single-pass ops; MUL picks its code per iteration.
    function automatic logic [2:0] aluCodeFor(op_e op);
        case (op)
            OP_ADD:                 return ALU_ADD;
            OP_SUB, OP_NEG, OP_CMP: return ALU_SUB;
            OP_INC:                 return ALU_INC;
            OP_DEC:                 return ALU_DEC;
            default:                return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake and flag bus between the issue logic (master)
// and the ALU operation sequencer (slave).
interface alu_op_sequencer_if #(parameter int WIDTH = 8);

    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_lo;
    logic [WIDTH-1:0] rsp_hi;
    logic             flag_v;
    logic             flag_c;
    logic             flag_n;
    logic             flag_z;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_lo, rsp_hi,
               flag_v, flag_c, flag_n, flag_z
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_lo, rsp_hi,
               flag_v, flag_c, flag_n, flag_z
    );

endinterface

// File: rtl/alu_basic.sv
// aluBasic: combinational 8-bit adder-based ALU (pass/inc/add/sub/dec) with
// V/C/N/Z flags; C is the adder carry-out, so for SUB it means "no borrow".
module aluBasic
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       code,
    output logic [WIDTH-1:0] sum,
    output logic             v,
    output logic             c,
    output logic             n,
    output logic             z
);

    logic [WIDTH-1:0] addend;
    logic             carryIn;
    logic             useAdder;
    logic [WIDTH:0]   ext;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the case can leave it unassigned and infer a latch.
    always_comb begin
        addend   = '0;
        carryIn  = 1'b0;
        useAdder = 1'b1;
        case (code)
            ALU_INC: carryIn = 1'b1;
            ALU_ADD: addend  = b;
            ALU_SUB: begin
                addend  = ~b;
                carryIn = 1'b1;
            end
            ALU_DEC: addend = '1;
            default: useAdder = 1'b0;
        endcase

        ext = {1'b0, a} + {1'b0, addend} + (WIDTH+1)'(carryIn);

        if (useAdder) begin
            sum = ext[WIDTH-1:0];
            c   = ext[WIDTH];
            v   = (a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end else begin
            sum = (code == ALU_PASS) ? a : '0;
            c   = 1'b0;
            v   = 1'b0;
        end
        n = sum[WIDTH-1];
        z = (sum == '0);
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Request/response front end for aluBasic: single-pass ops take one EXEC cycle,
// MUL runs a MUL_ITER-step shift-and-add through the same external ALU.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH    = SEQ_WIDTH,
    parameter int MUL_ITER = SEQ_MUL_ITER
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_op_sequencer_if.slave    bus,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [2:0]           alu_code,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_v,
    input  logic                 alu_c,
    input  logic                 alu_n,
    input  logic                 alu_z
);

    localparam logic [2:0] LAST_ITER = 3'(MUL_ITER - 1);

    state_e           state;
    state_e           stateNext;
    op_e              opQ;
    logic [WIDTH-1:0] aQ;
    logic [WIDTH-1:0] bQ;
    logic [WIDTH-1:0] pHi;
    logic [WIDTH-1:0] pLo;
    logic [2:0]       iterCnt;
    logic             rspValidQ;
    logic [WIDTH-1:0] rspLoQ;
    logic [WIDTH-1:0] rspHiQ;
    logic             flagVQ, flagCQ, flagNQ, flagZQ;

    logic             accept;
    logic             lastIter;
    logic             mulCarry;
    logic [WIDTH-1:0] mulHi;
    logic [WIDTH-1:0] mulLo;

    assign accept   = bus.req_valid && (state == IDLE);
    assign lastIter = (iterCnt == LAST_ITER);

    // A PASS iteration (multiplier bit 0) never carries into the product.
    assign mulCarry = pLo[0] & alu_c;
    assign mulHi    = {mulCarry, alu_result[WIDTH-1:1]};
    assign mulLo    = {alu_result[0], pLo[WIDTH-1:1]};

    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.rsp_valid = rspValidQ;
    assign bus.rsp_lo    = rspLoQ;
    assign bus.rsp_hi    = rspHiQ;
    assign bus.flag_v    = flagVQ;
    assign bus.flag_c    = flagCQ;
    assign bus.flag_n    = flagNQ;
    assign bus.flag_z    = flagZQ;

    // NOTE: registers use non-blocking assignments so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        alu_a     = '0;
        alu_b     = '0;
        alu_code  = ALU_PASS;
        case (state)
            IDLE: if (accept) stateNext = (op_e'(bus.req_op) == OP_MUL) ? MUL : EXEC;
            EXEC: begin
                alu_a     = (opQ == OP_NEG) ? '0 : aQ;
                alu_b     = bQ;
                alu_code  = aluCodeFor(opQ);
                stateNext = DONE;
            end
            MUL: begin
                alu_a    = pHi;
                alu_b    = aQ;
                alu_code = pLo[0] ? ALU_ADD : ALU_PASS;
                if (lastIter) stateNext = DONE;
            end
            DONE: if (rspValidQ && bus.rsp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opQ       <= OP_ADD;
            aQ        <= '0;
            bQ        <= '0;
            pHi       <= '0;
            pLo       <= '0;
            iterCnt   <= '0;
            rspValidQ <= 1'b0;
            rspLoQ    <= '0;
            rspHiQ    <= '0;
            flagVQ    <= 1'b0;
            flagCQ    <= 1'b0;
            flagNQ    <= 1'b0;
            flagZQ    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    opQ     <= op_e'(bus.req_op);
                    aQ      <= bus.req_a;
                    bQ      <= bus.req_b;
                    pHi     <= '0;
                    pLo     <= bus.req_b;
                    iterCnt <= '0;
                end
                EXEC: begin
                    rspLoQ <= (opQ == OP_CMP) ? aQ : alu_result;
                    rspHiQ <= '0;
                    flagVQ <= alu_v;
                    flagCQ <= alu_c;
                    flagNQ <= alu_n;
                    flagZQ <= alu_z;
                end
                MUL: begin
                    pHi     <= mulHi;
                    pLo     <= mulLo;
                    iterCnt <= iterCnt + 3'd1;
                    if (lastIter) begin
                        rspHiQ <= mulHi;
                        rspLoQ <= mulLo;
                        flagVQ <= 1'b0;
                        flagCQ <= (mulHi != '0);
                        flagNQ <= mulHi[WIDTH-1];
                        flagZQ <= ({mulHi, mulLo} == '0);
                    end
                end
                DONE: begin
                    // Response goes valid one cycle after entering DONE.
                    if (!rspValidQ)          rspValidQ <= 1'b1;
                    else if (bus.rsp_ready)  rspValidQ <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer driving a real aluBasic: the driver
// pushes model results, the monitor compares every cycle a response is shown.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.WIDTH(W)) bus();

    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_code;
    logic         alu_v, alu_c, alu_n, alu_z;

    alu_op_sequencer #(.WIDTH(W), .MUL_ITER(8)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code),
        .alu_result(alu_result),
        .alu_v(alu_v), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z)
    );

    aluBasic #(.WIDTH(W)) alu (
        .a(alu_a), .b(alu_b), .code(alu_code), .sum(alu_result),
        .v(alu_v), .c(alu_c), .n(alu_n), .z(alu_z)
    );

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [3:0] vcnz;
        int         latency;
        int         acceptCycle;
        string      name;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cycle      = 0;
    int   stallCycles = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference results from plain integer arithmetic on the op definitions.
    function automatic exp_t model(op_e op, logic [7:0] a, logic [7:0] b);
        exp_t e;
        int ua, ub, sa, sb, full, sfull;
        logic v, c;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        e.hi = 8'h00; e.latency = 2; e.acceptCycle = 0; e.name = op.name();
        c = 1'b0;
        full = 0; sfull = 0;
        case (op)
            OP_ADD:         begin full = ua + ub; sfull = sa + sb; c = (full > 255); end
            OP_INC:         begin full = ua + 1;  sfull = sa + 1;  c = (full > 255); end
            OP_SUB, OP_CMP: begin full = ua - ub; sfull = sa - sb; c = (ua >= ub);   end
            OP_DEC:         begin full = ua - 1;  sfull = sa - 1;  c = (ua >= 1);    end
            OP_NEG:         begin full = -ub;     sfull = -sb;     c = (ub == 0);    end
            OP_PASS:        begin full = ua;      sfull = sa;      c = 1'b0;         end
            default:        begin full = ua * ub; sfull = 0; end
        endcase
        if (op == OP_MUL) begin
            e.lo = full[7:0];
            e.hi = full[15:8];
            e.vcnz = {1'b0, (e.hi != 0), full[15], (full == 0)};
            e.latency = 9;
        end else begin
            v = (sfull > 127) || (sfull < -128);
            e.lo = full[7:0];
            e.vcnz = {v, c, e.lo[7], (e.lo == 8'h00)};
            if (op == OP_CMP) e.lo = a;
        end
        return e;
    endfunction

    task automatic send(input op_e op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int waitN = 0;
        @(negedge clk);
        while (!bus.req_ready && waitN < 50) begin
            @(negedge clk);
            waitN++;
        end
        if (!bus.req_ready) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            return;
        end
        bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1;
        @(negedge clk);
        e = model(op, a, b);
        e.acceptCycle = cycle;
        expQ.push_back(e);
        bus.req_valid = 1'b0;
        // Later request-bus activity must not affect the latched operation.
        bus.req_op = 3'($urandom); bus.req_a = 8'($urandom); bus.req_b = 8'($urandom);
    endtask

    task automatic waitDone();
        int waitN = 0;
        while (expQ.size() != 0 && waitN < 60) begin
            @(negedge clk);
            waitN++;
        end
        if (expQ.size() != 0) begin
            check("rsp_timeout", 32'(expQ.size()), 32'd0);
            expQ.delete();
        end
    endtask

    task automatic issue(input op_e op, input logic [7:0] a, input logic [7:0] b);
        send(op, a, b);
        waitDone();
    endtask

    // Monitor: compares every cycle a response is presented, pops on handshake.
    initial begin
        exp_t e;
        logic prevValid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevValid     = 1'b0;
                bus.rsp_ready = 1'b0;
            end else begin
                if (bus.rsp_valid) begin
                    if (expQ.size() == 0) begin
                        check("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = expQ[0];
                        if (!prevValid)
                            check({e.name, "_latency"}, 32'(cycle - e.acceptCycle), 32'(e.latency));
                        check({e.name, "_lo"}, 32'(bus.rsp_lo), 32'(e.lo));
                        check({e.name, "_hi"}, 32'(bus.rsp_hi), 32'(e.hi));
                        check({e.name, "_vcnz"},
                              32'({bus.flag_v, bus.flag_c, bus.flag_n, bus.flag_z}), 32'(e.vcnz));
                        check({e.name, "_req_ready_busy"}, 32'(bus.req_ready), 32'd0);
                    end
                end
                prevValid = bus.rsp_valid;
                if (stallCycles > 0 && bus.rsp_valid) begin
                    bus.rsp_ready = 1'b0;
                    stallCycles--;
                end else begin
                    bus.rsp_ready = ($urandom_range(3) != 0);
                end
                if (bus.rsp_valid && bus.rsp_ready && expQ.size() != 0) void'(expQ.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waitN;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_req_ready_in_rst", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check("reset_rsp", 32'({bus.rsp_valid, bus.rsp_hi, bus.rsp_lo}), 32'd0);
        check("reset_flags", 32'({bus.flag_v, bus.flag_c, bus.flag_n, bus.flag_z}), 32'd0);
        check("reset_alu", 32'({alu_a, alu_b, alu_code}), 32'd0);

        // Directed cases, including flag and wrap boundaries.
        issue(OP_ADD, 8'h7F, 8'h01);
        issue(OP_SUB, 8'h05, 8'h05);
        issue(OP_CMP, 8'h03, 8'h05);
        issue(OP_MUL, 8'hFF, 8'hFF);
        issue(OP_MUL, 8'h00, 8'h37);
        issue(OP_MUL, 8'h0C, 8'h0A);
        issue(OP_INC, 8'hFF, 8'h12);
        issue(OP_DEC, 8'h00, 8'h34);
        issue(OP_NEG, 8'h56, 8'h80);
        issue(OP_NEG, 8'h56, 8'h00);
        issue(OP_PASS, 8'h80, 8'hAA);

        for (int i = 0; i < 80; i++)
            issue(op_e'($urandom_range(7)), 8'($urandom), 8'($urandom));

        // Backpressure: response held 5 cycles while a new request waits.
        stallCycles = 5;
        send(OP_ADD, 8'hC3, 8'h5A);
        waitN = 0;
        while (!bus.rsp_valid && waitN < 20) begin
            @(negedge clk);
            waitN++;
        end
        check("bp_rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
        bus.req_op = OP_INC; bus.req_a = 8'h11; bus.req_b = 8'h22; bus.req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            check("bp_rsp_held", 32'(bus.rsp_valid), 32'd1);
        end
        bus.req_valid = 1'b0;
        waitDone();
        stallCycles = 0;

        // Reset during MUL iteration 4 aborts without a response.
        issue(OP_SUB, 8'h10, 8'h20);
        send(OP_MUL, 8'hAB, 8'hFF);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        expQ.delete();
        check("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_mid_rsp", 32'({bus.rsp_hi, bus.rsp_lo}), 32'd0);
        check("rst_mid_flags", 32'({bus.flag_v, bus.flag_c, bus.flag_n, bus.flag_z}), 32'd0);
        check("rst_mid_alu", 32'({alu_a, alu_b, alu_code}), 32'd0);
        check("rst_mid_req_ready", 32'(bus.req_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_req_ready", 32'(bus.req_ready), 32'd1);
        repeat (12) @(negedge clk);
        issue(OP_ADD, 8'h01, 8'h02);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
